// File: rtl/reg_bus_pkg.sv
// Shared widths, FSM state encoding and command record for the peripheral register bus.
// Imported by the initiator, its interface and anything that builds commands for it.
package reg_bus_pkg;

  localparam int REG_BUS_ADDR_W = 16;
  localparam int REG_BUS_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    RSP
  } reg_bus_init_state_t;

  typedef struct packed {
    logic                          write;
    logic [REG_BUS_ADDR_W-1:0]     addr;
    logic [REG_BUS_DATA_W-1:0]     wdata;
    logic [REG_BUS_DATA_W/8-1:0]   be;
  } reg_bus_cmd_t;

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Command/response handshake plus peripheral register bus signals for one initiator.
// master = the initiator itself; slave = the command source, response sink and bus responder.
interface reg_bus_initiator_if
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = REG_BUS_ADDR_W,
  parameter int DATA_W = REG_BUS_DATA_W
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_W-1:0]     rsp_rdata;

  logic [ADDR_W-1:0]     read_addr;
  logic                  oe;
  logic [DATA_W-1:0]     read_data;
  logic [ADDR_W-1:0]     write_addr;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W/8-1:0]   be;
  logic                  we;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready, read_data,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output read_addr, oe, write_addr, write_data, be, we
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready, read_data,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  read_addr, oe, write_addr, write_data, be, we
  );

endinterface

// File: rtl/reg_bus_initiator.sv
// Register bus initiator: one command at a time, one-cycle we/oe strobe, response held until consumed.
// Latency: write 3 cycles, read 3+READ_LATENCY cycles; cmd_ready only in IDLE, response stalls on rsp_ready.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W       = REG_BUS_ADDR_W,
  parameter int DATA_W       = REG_BUS_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  reg_bus_initiator_if.master bus
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
      $error("READ_LATENCY must be in 1..4");
    end
  endgenerate

  reg_bus_init_state_t state, state_n;
  logic [1:0]          lat_cnt, lat_cnt_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [BE_W-1:0]     be_q, be_n;
  logic                accept;

  // Gated with reset so the source never sees a ready while we are held in reset.
  assign bus.cmd_ready = (state == IDLE) && !reset;

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    accept    = (state == IDLE) && bus.cmd_valid;
    addr_n    = accept ? bus.cmd_addr  : addr_q;
    wdata_n   = accept ? bus.cmd_wdata : wdata_q;
    be_n      = accept ? bus.cmd_be    : be_q;
    case (state)
      IDLE: if (bus.cmd_valid) state_n = bus.cmd_write ? WR : RD;
      WR:   state_n = RSP;
      RD: begin
        state_n   = WAIT;
        lat_cnt_n = LAT_LOAD;
      end
      WAIT: begin
        if (lat_cnt == 2'd0) state_n = RSP;
        else                 lat_cnt_n = lat_cnt - 2'd1;
      end
      RSP:  if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= 2'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      bus.oe         <= 1'b0;
      bus.read_addr  <= '0;
      bus.we         <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
      bus.be         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_write  <= 1'b0;
      bus.rsp_rdata  <= '0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      be_q    <= be_n;

      // Strobes are registered off the next state, so each is high for exactly the RD/WR cycle.
      bus.oe         <= (state_n == RD);
      bus.read_addr  <= (state_n == RD) ? addr_n  : '0;
      bus.we         <= (state_n == WR);
      bus.write_addr <= (state_n == WR) ? addr_n  : '0;
      bus.write_data <= (state_n == WR) ? wdata_n : '0;
      bus.be         <= (state_n == WR) ? be_n    : '0;

      bus.rsp_valid <= (state_n == RSP);
      if (state == WR) begin
        bus.rsp_write <= 1'b1;
        bus.rsp_rdata <= '0;
      end else if (state == WAIT && lat_cnt == 2'd0) begin
        bus.rsp_write <= 1'b0;
        bus.rsp_rdata <= bus.read_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench: latency-1 initiator against a timer/register responder, latency-3 initiator
// against a delay-line responder that only presents good data on the expected cycle.
module tb_reg_bus_initiator;
  import reg_bus_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clock = ~clock;

  reg_bus_initiator_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
  reg_bus_initiator_if #(.ADDR_W(16), .DATA_W(32)) b2 ();

  reg_bus_initiator #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .bus(b1.master));
  reg_bus_initiator #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .bus(b2.master));

  // Timer-style responder: address 0 is a free-running counter, others are byte-maskable registers.
  logic [31:0] timer;
  logic [31:0] regs [0:15];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= 32'd0;
      b1.read_data <= 32'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else begin
      timer <= timer + 32'd1;
      if (b1.we)
        for (int i = 0; i < 4; i++)
          if (b1.be[i]) regs[b1.write_addr[5:2]][8*i +: 8] <= b1.write_data[8*i +: 8];
      if (b1.oe) b1.read_data <= (b1.read_addr == 16'd0) ? timer : regs[b1.read_addr[5:2]];
    end
  end

  // Delay-line responder: garbage on every cycle except the third after the oe cycle.
  logic d1, d2, d3;
  always @(posedge clock or posedge reset) begin
    if (reset) {d1, d2, d3} <= 3'b000;
    else       {d1, d2, d3} <= {b2.oe, d1, d2};
  end
  assign b2.read_data = d3 ? 32'h12345678 : {16'hBAD0, timer[15:0]};

  task automatic send1(input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] bev, output bit ok);
    int n = 0;
    b1.cmd_write = w; b1.cmd_addr = a; b1.cmd_wdata = d; b1.cmd_be = bev; b1.cmd_valid = 1'b1;
    while (!b1.cmd_ready && n < 50) begin @(negedge clock); n++; end
    ok = b1.cmd_ready;
    @(posedge clock); #1 b1.cmd_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] a, output bit ok);
    int n = 0;
    b2.cmd_write = 1'b0; b2.cmd_addr = a; b2.cmd_wdata = 32'd0; b2.cmd_be = 4'd0; b2.cmd_valid = 1'b1;
    while (!b2.cmd_ready && n < 50) begin @(negedge clock); n++; end
    ok = b2.cmd_ready;
    @(posedge clock); #1 b2.cmd_valid = 1'b0;
  endtask

  task automatic finish1(output logic wr, output logic [31:0] rd, output bit ok);
    int n = 0;
    while (!b1.rsp_valid && n < 20) begin @(negedge clock); n++; end
    ok = b1.rsp_valid; wr = b1.rsp_write; rd = b1.rsp_rdata;
    b1.rsp_ready = 1'b1;
    @(posedge clock); #1 b1.rsp_ready = 1'b0;
  endtask

  task automatic finish2(output logic [31:0] rd, output bit ok);
    int n = 0;
    while (!b2.rsp_valid && n < 20) begin @(negedge clock); n++; end
    ok = b2.rsp_valid; rd = b2.rsp_rdata;
    b2.rsp_ready = 1'b1;
    @(posedge clock); #1 b2.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if (b1.cmd_ready !== 1'b0) begin n_fails++; $display("FAIL reset_cmd_ready1 got %b want 0", b1.cmd_ready); end
    n_checks++; if (b2.cmd_ready !== 1'b0) begin n_fails++; $display("FAIL reset_cmd_ready3 got %b want 0", b2.cmd_ready); end
    n_checks++; if ({b1.oe, b1.we, b1.rsp_valid} !== 3'b000) begin n_fails++; $display("FAIL reset_strobes got %b want 000", {b1.oe, b1.we, b1.rsp_valid}); end
    n_checks++; if ({b1.write_addr, b1.rsp_rdata} !== 48'd0) begin n_fails++; $display("FAIL reset_data got %h want 0", {b1.write_addr, b1.rsp_rdata}); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if ({b1.cmd_ready, b2.cmd_ready} !== 2'b11) begin n_fails++; $display("FAIL release_cmd_ready got %b want 11", {b1.cmd_ready, b2.cmd_ready}); end
  endtask

  task automatic test_write();
    bit ok;
    send1(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL write_accept timed out"); end
    @(negedge clock);
    n_checks++; if ({b1.we, b1.oe, b1.cmd_ready} !== 3'b100) begin n_fails++; $display("FAIL write_strobe we/oe/rdy got %b want 100", {b1.we, b1.oe, b1.cmd_ready}); end
    n_checks++; if (b1.write_addr !== 16'h0004) begin n_fails++; $display("FAIL write_addr got %h want 0004", b1.write_addr); end
    n_checks++; if (b1.write_data !== 32'hDEADBEEF) begin n_fails++; $display("FAIL write_data got %h want deadbeef", b1.write_data); end
    n_checks++; if (b1.be !== 4'hF) begin n_fails++; $display("FAIL write_be got %h want f", b1.be); end
    @(negedge clock);
    n_checks++; if ({b1.we, b1.write_data} !== 33'd0) begin n_fails++; $display("FAIL write_drop got %h want 0", {b1.we, b1.write_data}); end
    n_checks++; if ({b1.rsp_valid, b1.rsp_write} !== 2'b11) begin n_fails++; $display("FAIL write_ack got %b want 11", {b1.rsp_valid, b1.rsp_write}); end
    n_checks++; if (b1.rsp_rdata !== 32'd0) begin n_fails++; $display("FAIL write_ack_rdata got %h want 0", b1.rsp_rdata); end
    b1.rsp_ready = 1'b1;
    @(negedge clock);
    n_checks++; if ({b1.rsp_valid, b1.cmd_ready} !== 2'b01) begin n_fails++; $display("FAIL write_done valid/rdy got %b want 01", {b1.rsp_valid, b1.cmd_ready}); end
    b1.rsp_ready = 1'b0;
  endtask

  task automatic test_read_lat1();
    bit ok;
    logic [31:0] exp_t;
    send1(1'b0, 16'h0000, 32'd0, 4'd0, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL rd1_accept timed out"); end
    @(negedge clock);
    exp_t = timer;
    n_checks++; if ({b1.oe, b1.we, b1.cmd_ready} !== 3'b100) begin n_fails++; $display("FAIL rd1_strobe oe/we/rdy got %b want 100", {b1.oe, b1.we, b1.cmd_ready}); end
    @(negedge clock);
    n_checks++; if ({b1.oe, b1.rsp_valid} !== 2'b00) begin n_fails++; $display("FAIL rd1_wait oe/valid got %b want 00", {b1.oe, b1.rsp_valid}); end
    @(negedge clock);
    n_checks++; if ({b1.rsp_valid, b1.rsp_write} !== 2'b10) begin n_fails++; $display("FAIL rd1_rsp valid/write got %b want 10", {b1.rsp_valid, b1.rsp_write}); end
    n_checks++; if (b1.rsp_rdata !== exp_t) begin n_fails++; $display("FAIL rd1_timer got %h want %h", b1.rsp_rdata, exp_t); end
    b1.rsp_ready = 1'b1;
    @(posedge clock); #1 b1.rsp_ready = 1'b0;
  endtask

  task automatic test_byte_enables();
    bit ok; logic wr; logic [31:0] rd;
    send1(1'b1, 16'h0008, 32'hAABBCCDD, 4'h5, ok); finish1(wr, rd, ok);
    send1(1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, ok);
    @(negedge clock);
    n_checks++; if ({b1.we, b1.be} !== 5'b1_0000) begin n_fails++; $display("FAIL be_zero_strobe we/be got %b want 10000", {b1.we, b1.be}); end
    finish1(wr, rd, ok);
    n_checks++; if (!ok || wr !== 1'b1) begin n_fails++; $display("FAIL be_zero_ack ok/write got %b%b want 11", ok, wr); end
    send1(1'b0, 16'h0008, 32'd0, 4'd0, ok); finish1(wr, rd, ok);
    n_checks++; if (rd !== 32'h00BB00DD) begin n_fails++; $display("FAIL be_partial got %h want 00bb00dd", rd); end
    send1(1'b0, 16'h0004, 32'd0, 4'd0, ok); finish1(wr, rd, ok);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fails++; $display("FAIL be_zero_kept got %h want deadbeef", rd); end
  endtask

  task automatic test_latency3();
    bit ok; logic [31:0] rd;
    send2(16'h0010, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL lat3_accept timed out"); end
    @(negedge clock);
    n_checks++; if ({b2.oe, b2.read_addr} !== {1'b1, 16'h0010}) begin n_fails++; $display("FAIL lat3_strobe got %h want 10010", {b2.oe, b2.read_addr}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if ({b2.oe, b2.rsp_valid} !== 2'b00) begin n_fails++; $display("FAIL lat3_wait%0d oe/valid got %b want 00", i, {b2.oe, b2.rsp_valid}); end
    end
    @(negedge clock);
    n_checks++; if (b2.rsp_valid !== 1'b1) begin n_fails++; $display("FAIL lat3_valid got %b want 1", b2.rsp_valid); end
    finish2(rd, ok);
    n_checks++; if (rd !== 32'h12345678) begin n_fails++; $display("FAIL lat3_data got %h want 12345678", rd); end
  endtask

  task automatic test_backpressure();
    bit ok; logic wr; logic [31:0] rd;
    int n = 0;
    send1(1'b0, 16'h0004, 32'd0, 4'd0, ok);
    while (!b1.rsp_valid && n < 20) begin @(negedge clock); n++; end
    b1.cmd_write = 1'b1; b1.cmd_addr = 16'h0020; b1.cmd_wdata = 32'h00005555; b1.cmd_be = 4'hF; b1.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if ({b1.rsp_valid, b1.cmd_ready, b1.oe, b1.we} !== 4'b1000) begin n_fails++; $display("FAIL bp_hold%0d valid/rdy/oe/we got %b want 1000", i, {b1.rsp_valid, b1.cmd_ready, b1.oe, b1.we}); end
      n_checks++; if (b1.rsp_rdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL bp_data%0d got %h want deadbeef", i, b1.rsp_rdata); end
      @(negedge clock);
    end
    b1.rsp_ready = 1'b1;
    @(posedge clock); #1 b1.rsp_ready = 1'b0;
    @(negedge clock);
    n_checks++; if ({b1.rsp_valid, b1.cmd_ready} !== 2'b01) begin n_fails++; $display("FAIL bp_release valid/rdy got %b want 01", {b1.rsp_valid, b1.cmd_ready}); end
    @(posedge clock); #1 b1.cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++; if ({b1.we, b1.write_addr} !== {1'b1, 16'h0020}) begin n_fails++; $display("FAIL bp_next_write got %h want 10020", {b1.we, b1.write_addr}); end
    finish1(wr, rd, ok);
    n_checks++; if (!ok || wr !== 1'b1) begin n_fails++; $display("FAIL bp_next_ack ok/write got %b%b want 11", ok, wr); end
  endtask

  task automatic test_back_to_back();
    reg_bus_cmd_t vec [4];
    logic [31:0]  exp_rd [4];
    logic [16:0]  strb [8];
    logic [32:0]  rsps [8];
    int n_strb = 0, n_rsp = 0, n_ovl = 0, n_to = 0;
    vec[0] = '{write: 1'b1, addr: 16'h000C, wdata: 32'h11112222, be: 4'hF};
    vec[1] = '{write: 1'b0, addr: 16'h000C, wdata: 32'h0,        be: 4'h0};
    vec[2] = '{write: 1'b1, addr: 16'h000C, wdata: 32'h33334444, be: 4'h3};
    vec[3] = '{write: 1'b0, addr: 16'h000C, wdata: 32'h0,        be: 4'h0};
    exp_rd = '{32'h0, 32'h11112222, 32'h0, 32'h11114444};
    b1.rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int n = 0;
          b1.cmd_write = vec[i].write; b1.cmd_addr = vec[i].addr;
          b1.cmd_wdata = vec[i].wdata; b1.cmd_be = vec[i].be; b1.cmd_valid = 1'b1;
          while (!b1.cmd_ready && n < 50) begin @(negedge clock); n++; end
          if (!b1.cmd_ready) n_to++;
          @(posedge clock); #1;
        end
        b1.cmd_valid = 1'b0;
      end
      begin
        repeat (40) begin
          @(negedge clock);
          if (b1.oe && b1.we) n_ovl++;
          if ((b1.oe || b1.we) && n_strb < 8) begin strb[n_strb] = {b1.we, b1.we ? b1.write_addr : b1.read_addr}; n_strb++; end
          if (b1.rsp_valid && n_rsp < 8) begin rsps[n_rsp] = {b1.rsp_write, b1.rsp_rdata}; n_rsp++; end
        end
      end
    join
    b1.rsp_ready = 1'b0;
    n_checks++; if (n_to != 0) begin n_fails++; $display("FAIL b2b_accept timeouts got %0d want 0", n_to); end
    n_checks++; if (n_ovl != 0) begin n_fails++; $display("FAIL b2b_overlap got %0d want 0", n_ovl); end
    n_checks++; if (n_strb != 4) begin n_fails++; $display("FAIL b2b_strobe_count got %0d want 4", n_strb); end
    n_checks++; if (n_rsp != 4) begin n_fails++; $display("FAIL b2b_rsp_count got %0d want 4", n_rsp); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (strb[i] !== {vec[i].write, vec[i].addr}) begin n_fails++; $display("FAIL b2b_strobe%0d got %h want %h", i, strb[i], {vec[i].write, vec[i].addr}); end
      n_checks++; if (rsps[i] !== {vec[i].write, exp_rd[i]}) begin n_fails++; $display("FAIL b2b_rsp%0d got %h want %h", i, rsps[i], {vec[i].write, exp_rd[i]}); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic wr; logic [31:0] rd;
    int seen = 0;
    send1(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, ok);
    @(negedge clock);
    n_checks++; if (b1.we !== 1'b1) begin n_fails++; $display("FAIL rstmid_we_before got %b want 1", b1.we); end
    reset = 1'b1;
    #1;
    n_checks++; if ({b1.we, b1.write_data, b1.be} !== 37'd0) begin n_fails++; $display("FAIL rstmid_we_drop got %h want 0", {b1.we, b1.write_data, b1.be}); end
    @(negedge clock);
    reset = 1'b0;
    send2(16'h0010, ok);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++; if ({b2.oe, b2.we, b2.rsp_valid, b2.cmd_ready} !== 4'b0000) begin n_fails++; $display("FAIL rstmid_wait got %b want 0000", {b2.oe, b2.we, b2.rsp_valid, b2.cmd_ready}); end
    @(negedge clock);
    reset = 1'b0;
    b1.rsp_ready = 1'b1; b2.rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (b1.rsp_valid || b2.rsp_valid) seen++;
    end
    b1.rsp_ready = 1'b0; b2.rsp_ready = 1'b0;
    n_checks++; if (seen != 0) begin n_fails++; $display("FAIL rstmid_no_rsp got %0d responses want 0", seen); end
    send2(16'h0010, ok); finish2(rd, ok);
    n_checks++; if (!ok || rd !== 32'h12345678) begin n_fails++; $display("FAIL rstmid_lat3_after ok=%b got %h want 12345678", ok, rd); end
    send1(1'b1, 16'h0008, 32'h0F0F0F0F, 4'hF, ok); finish1(wr, rd, ok);
    send1(1'b0, 16'h0008, 32'd0, 4'd0, ok); finish1(wr, rd, ok);
    n_checks++; if (!ok || rd !== 32'h0F0F0F0F) begin n_fails++; $display("FAIL rstmid_lat1_after ok=%b got %h want 0f0f0f0f", ok, rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.cmd_valid = 1'b0; b1.cmd_write = 1'b0; b1.cmd_addr = '0; b1.cmd_wdata = '0; b1.cmd_be = '0; b1.rsp_ready = 1'b0;
    b2.cmd_valid = 1'b0; b2.cmd_write = 1'b0; b2.cmd_addr = '0; b2.cmd_wdata = '0; b2.cmd_be = '0; b2.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read_lat1();
    test_byte_enables();
    test_latency3();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
